// File: rtl/myfilter_pkg.sv
// Shared definitions for the I2C receive front end of the filter.
//   i2c_rx_state_t        : receiver FSM states
//   I2C_GENERAL_CALL_ADDR : 7-bit general-call address (answered only when
//                           I2C_GENERAL_CALL_EN is defined)
//   I2C_BYTE_BITS         : bits per I2C byte
package myfilter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } i2c_rx_state_t;

  localparam logic [6:0] I2C_GENERAL_CALL_ADDR = 7'h00;
  localparam int         I2C_BYTE_BITS         = 8;

endpackage

// File: rtl/i2c_rx_shifter.sv
// Serial-to-parallel shifter for the I2C receiver.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : synchronous clear of shift register and bit counter
//   shift_en   : qualified SCL rise; shift sda into the LSB
//   sda        : synchronised SDA level
//   shift_q    : current shift register contents
//   byte_next  : value the shift register takes on this shift
//   byte_done  : strobe, this shift is the 8th bit of a byte
module i2c_rx_shifter
  import myfilter_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     shift_en,
  input  logic                     sda,
  output logic [I2C_BYTE_BITS-1:0] shift_q,
  output logic [I2C_BYTE_BITS-1:0] byte_next,
  output logic                     byte_done
);

  localparam int CW = $clog2(I2C_BYTE_BITS);

  logic [CW-1:0] bit_cnt;

  assign byte_next = {shift_q[I2C_BYTE_BITS-2:0], sda};
  // The counter wraps to 0 after the last bit, so the next byte starts clean.
  assign byte_done = shift_en && (bit_cnt == CW'(I2C_BYTE_BITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shift_q <= byte_next;
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_slave_rx_svamod.sv
// Assertion companion for i2c_slave_rx, bound into every instance in
// non-synthesis builds.
//   X-checks all outputs; checks that a data load and an overrun never
//   happen in the same cycle.
module i2c_slave_rx_svamod (
  input logic       clk,
  input logic       rst,
  input logic       sda_drive_out,
  input logic [7:0] data_out,
  input logic       data_valid_out,
  input logic       busy_out,
  input logic       overrun_out,
  input logic       data_load,
  input logic       overrun_set
);

  a_outputs_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({sda_drive_out, data_out, data_valid_out, busy_out, overrun_out}));

  a_load_overrun_excl: assert property (@(posedge clk) disable iff (rst)
    !(data_load && overrun_set));

endmodule

`ifndef SYNTHESIS
bind i2c_slave_rx i2c_slave_rx_svamod u_svamod (
  .clk            (clk),
  .rst            (rst),
  .sda_drive_out  (sda_drive_out),
  .data_out       (data_out),
  .data_valid_out (data_valid_out),
  .busy_out       (busy_out),
  .overrun_out    (overrun_out),
  .data_load      (data_load),
  .overrun_set    (overrun_set)
);
`endif

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver, fed by the start/stop/edge detector.
// Optional feature macro: I2C_GENERAL_CALL_EN (also ACK address 7'h00, W).
//   clk, rst        : clock, asynchronous active-high reset
//   sda_in          : synchronised SDA level
//   start_in        : START / repeated-START pulse (highest priority)
//   stop_in         : STOP pulse
//   scl_rise_in     : SCL rising-edge pulse (data sample point)
//   scl_fall_in     : SCL falling-edge pulse (SDA change point)
//   data_ready_in   : consumer accepts data_out this cycle
//   sda_drive_out   : 1 = pull SDA low (ACK)
//   data_out        : last received data byte
//   data_valid_out  : data_out holds an unconsumed byte
//   busy_out        : addressed, transaction in progress
//   overrun_out     : one-cycle pulse, byte dropped because the slot was full
// Handshake: a byte transfers on any cycle with data_valid_out and
// data_ready_in both high; data_out is stable while data_valid_out is high
// and not accepted; a byte loading in the same cycle keeps valid high.
module i2c_slave_rx
  import myfilter_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sda_in,
  input  logic       start_in,
  input  logic       stop_in,
  input  logic       scl_rise_in,
  input  logic       scl_fall_in,
  input  logic       data_ready_in,
  output logic       sda_drive_out,
  output logic [7:0] data_out,
  output logic       data_valid_out,
  output logic       busy_out,
  output logic       overrun_out
);

  i2c_rx_state_t state, state_next;

  logic       byte_flag, byte_flag_next;  // 8 bits seen, waiting for SCL fall
  logic       drive_next;
  logic       ack_pending;
  logic       shift_en;
  logic       byte_done;
  logic [7:0] shift_q;
  logic [7:0] byte_next;
  logic       addr_match;
  logic       slot_free;
  logic       data_load;
  logic       overrun_set;

  // Events are ignored on a START or STOP cycle; those own the cycle.
  assign shift_en = scl_rise_in && !start_in && !stop_in &&
                    ((state == ST_ADDR) || (state == ST_DATA));

  i2c_rx_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_in || stop_in),
    .shift_en  (shift_en),
    .sda       (sda_in),
    .shift_q   (shift_q),
    .byte_next (byte_next),
    .byte_done (byte_done)
  );

`ifdef I2C_GENERAL_CALL_EN
  assign addr_match = !shift_q[0] && ((shift_q[7:1] == SLAVE_ADDR) ||
                                      (shift_q[7:1] == I2C_GENERAL_CALL_ADDR));
`else
  assign addr_match = !shift_q[0] && (shift_q[7:1] == SLAVE_ADDR);
`endif

  assign slot_free   = !data_valid_out || data_ready_in;
  assign data_load   = byte_done && (state == ST_DATA) && slot_free;
  assign overrun_set = byte_done && (state == ST_DATA) && !slot_free;

  always_comb begin
    state_next     = state;
    byte_flag_next = byte_flag;
    drive_next     = sda_drive_out;
    if (start_in) begin
      state_next     = ST_ADDR;
      byte_flag_next = 1'b0;
      drive_next     = 1'b0;
    end else if (stop_in) begin
      state_next     = ST_IDLE;
      byte_flag_next = 1'b0;
      drive_next     = 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (byte_done) begin
            byte_flag_next = 1'b1;
          end else if (scl_fall_in && byte_flag) begin
            byte_flag_next = 1'b0;
            if (addr_match) begin
              state_next = ST_ADDR_ACK;
              drive_next = 1'b1;
            end else begin
              state_next = ST_IGNORE;
            end
          end
        end
        ST_DATA: begin
          if (byte_done) begin
            byte_flag_next = 1'b1;
          end else if (scl_fall_in && byte_flag) begin
            byte_flag_next = 1'b0;
            state_next     = ST_DATA_ACK;
            drive_next     = ack_pending;
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall_in) begin
            state_next = ST_DATA;
            drive_next = 1'b0;
          end
        end
        default: ;  // IDLE and IGNORE wait for START/STOP only
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      byte_flag      <= 1'b0;
      sda_drive_out  <= 1'b0;
      ack_pending    <= 1'b0;
      data_out       <= 8'h00;
      data_valid_out <= 1'b0;
      busy_out       <= 1'b0;
      overrun_out    <= 1'b0;
    end else begin
      state         <= state_next;
      byte_flag     <= byte_flag_next;
      sda_drive_out <= drive_next;
      busy_out      <= (state_next == ST_ADDR_ACK) || (state_next == ST_DATA) ||
                       (state_next == ST_DATA_ACK);
      overrun_out   <= overrun_set;
      if (data_load) begin
        data_out       <= byte_next;
        data_valid_out <= 1'b1;
        ack_pending    <= 1'b1;
      end else begin
        if (data_ready_in) data_valid_out <= 1'b0;
        if (overrun_set)   ack_pending    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/i2c_slave_rx.md
# i2c_slave_rx

Write-only I2C slave receiver sitting directly downstream of the I2C start/stop/edge detector. Consumes its single-cycle `start`, `stop`, `scl_rise` and `scl_fall` event pulses plus the synchronised SDA level. Decodes the 7-bit address phase and drives the ACK/NACK bit. Delivers each received data byte over a valid/ready interface to the filter datapath.

## Interface
Parameters:
- `SLAVE_ADDR`, 7'h42, 7-bit address this slave answers to.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sda_in`  in  1  synchronised SDA level (same sample the detector uses).
- `start_in`  in  1  one-cycle START/repeated-START pulse.
- `stop_in`  in  1  one-cycle STOP pulse.
- `scl_rise_in`  in  1  one-cycle SCL rising-edge pulse.
- `scl_fall_in`  in  1  one-cycle SCL falling-edge pulse.
- `data_ready_in`  in  1  consumer accepts `data_out` this cycle.
- `sda_drive_out`  out  1  1 = pull SDA low (open-drain enable); 0 = release.
- `data_out`  out  8  last received data byte, MSB first on the bus.
- `data_valid_out`  out  1  `data_out` holds an unconsumed byte.
- `busy_out`  out  1  slave addressed and transaction in progress.
- `overrun_out`  out  1  one-cycle pulse: byte dropped because the output slot was full.

## Operation
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE: wait for `start_in`.
- `start_in` in any state goes to ADDR. It clears the bit counter and the shift register and releases SDA. It takes priority over every other event that cycle.
- `stop_in` in any state other than a START cycle goes to IDLE and releases SDA. A partial byte is discarded.
- ADDR and DATA: on `scl_rise_in`, shift `sda_in` into the LSB of the 8-bit shift register and increment the 3-bit bit counter (wraps 7 to 0).
- ADDR, after the 8th rise: address match is `shift[7:1] == SLAVE_ADDR` and R/W (`shift[0]`) `== 0`.
  - On the next `scl_fall_in`: on match, go to ADDR_ACK with ACK; otherwise go to IGNORE.
  - Read requests (R/W = 1) always NACK; this block is write-only.
- DATA, on the 8th rise, with the output slot free (`data_valid_out == 0`, or `data_ready_in == 1` this cycle):
  - load `data_out`;
  - set `data_valid_out`;
  - set the internal `ack_pending` flag.
- DATA, on the 8th rise, with the slot full:
  - keep `data_out`;
  - pulse `overrun_out`;
  - clear `ack_pending`.
- DATA, on the following `scl_fall_in`: go to DATA_ACK.
- ADDR_ACK / DATA_ACK:
  - `sda_drive_out` = ACK decision (ADDR_ACK always 1; DATA_ACK = `ack_pending`).
  - On the next `scl_fall_in`: release SDA and go to DATA.
- IGNORE: no drive and no shifting until `start_in` or `stop_in`.
- Handshake: `data_valid_out` clears on a cycle with `data_ready_in == 1`, unless a new byte loads in that same cycle (then it stays 1).
- `busy_out` = state in {ADDR_ACK, DATA, DATA_ACK}.

## Timing
- Reset values (async, immediate on `rst` high):
  - state IDLE, counter 0, shift register 8'h00;
  - `sda_drive_out` 0, `data_out` 8'h00, `data_valid_out` 0;
  - `busy_out` 0, `overrun_out` 0.
- All outputs are registered.
- Latency from the 8th data `scl_rise_in` cycle to `data_valid_out` high is 1 clock.
- `sda_drive_out` changes 1 clock after the `scl_fall_in` pulse that causes it, so it is stable well before the next SCL rise.
- `overrun_out` is high for exactly 1 clock, the cycle after the 8th rise.
- Reset mid-transfer releases SDA the same cycle (asynchronous). The slave then ignores the bus until the next `start_in`.

## Configuration
- `I2C_GENERAL_CALL_EN` defined: address 7'h00 with R/W = 0 is also ACKed, and the following bytes are received exactly as for `SLAVE_ADDR`.
- Undefined: 7'h00 goes to IGNORE like any non-matching address.

## Structure
- `myfilter_pkg` holds:
  - the state enum `i2c_rx_state_t`;
  - `I2C_GENERAL_CALL_ADDR` (7'h00);
  - `I2C_BYTE_BITS` (8).
- One sub-module, `i2c_rx_shifter`, holds the shift register, the bit counter and the `byte_done` strobe (the 8th rise). It is cleared by `start_in`.
- Companion assertion module `i2c_slave_rx_svamod` is bound in non-synthesis builds. It X-checks all outputs and checks that `overrun_out` and the data load are mutually exclusive.

## Test plan
- START, address 0x42 W, byte 0xA5, STOP, with `data_ready_in = 1` → ACK on both 9th clocks, `data_out = 8'hA5`, `data_valid_out` 1-cycle pulse, `busy_out` low after STOP.
- START, address 0x17 W, byte 0xFF → no `sda_drive_out` at any time, `data_valid_out` stays 0.
- START, 0x42 W, byte 0x11, repeated START, 0x42 W, byte 0x22, `data_ready_in = 1` → two ACKed bytes delivered in order (0x11, then 0x22).
- `data_ready_in = 0`, bytes 0x01 then 0x02 → `data_out = 8'h01` held, `overrun_out` pulses once, the second byte is NACKed.
- STOP after 4 data bits → IDLE, `data_valid_out` stays 0, SDA released.
- `rst` asserted during the address ACK → `sda_drive_out` drops 0 immediately; a following byte without START is ignored.
- With `I2C_GENERAL_CALL_EN`: address 0x00 W → ACK. Without it: NACK.
